// File: rtl/bit_extend_pipe.sv
// Bit-extension stage behind a 2-entry skid FIFO.
// The input word is widened when it is accepted, and the widened word is what gets buffered.
module bit_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    MODE_ZERO = 2'd0,
    MODE_SIGN = 2'd1,
    MODE_REPL = 2'd2,
    MODE_ONES = 2'd3
  } mode_e;

  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [OUT_W-1:0] mem_q [2];

  logic             fill;
  logic             repl;
  logic [OUT_W-1:0] ext_word;
  logic             push;
  logic             pop;

  always_comb begin
    fill = 1'b0;
    repl = 1'b0;
    unique case (mode_e'(in_mode))
      MODE_ZERO: fill = 1'b0;
      MODE_SIGN: fill = in_data[IN_W-1];
      MODE_REPL: begin
        fill = in_data[0];
        repl = 1'b1;
      end
      MODE_ONES: fill = 1'b1;
    endcase
  end

  // REPL overrides the low bits too; every other mode keeps in_data in the low field.
  for (genvar g = 0; g < OUT_W; g++) begin : g_ext
    if (g < IN_W) begin : g_lo
      assign ext_word[g] = repl ? in_data[0] : in_data[g];
    end else begin : g_hi
      assign ext_word[g] = fill;
    end
  end

  // rst_n gates ready so nothing is accepted while the block is held in reset.
  assign in_ready  = rst_n & (count_q < 2'd2) & ~flush;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          count_d  = count_q + 2'd1;
          wr_ptr_d = ~wr_ptr_q;
        end
        2'b01: begin
          count_d  = count_q - 2'd1;
          rd_ptr_d = ~rd_ptr_q;
        end
        2'b11: begin
          wr_ptr_d = ~wr_ptr_q;
          rd_ptr_d = ~rd_ptr_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) begin
        mem_q[wr_ptr_q] <= ext_word;
      end
    end
  end

endmodule
